// File: rtl/hex8_pkg.sv
// Shared constants, scan state type and timing helper for the 8-digit hex display controller.
package hex8_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] SEL_OFF = 8'hFF;

    // Common-anode patterns, entry n is nibble n; bit 7 (dp) is dark in every entry
    localparam logic [15:0][7:0] SEG_LUT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    function automatic int calc_scan_div(input int clk_freq, input int scan_freq);
        return clk_freq / scan_freq;
    endfunction

endpackage

// File: rtl/hex8_seg_decode.sv
// Combinational nibble-to-segment decoder producing an active-low common-anode byte.
module hex8_seg_decode
    import hex8_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    // A blanked digit keeps its decimal point dark as well
    always_comb begin
        seg = SEG_OFF;
        if (!blank) begin
            seg = SEG_LUT[nibble];
            if (dp) begin
                seg[7] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/hex8_scan_ctrl.sv
// Time-multiplexed scan controller: snapshots a 32-bit hex value per frame and
// emits one {seg, sel} word with a send strobe per digit slot for hc595_driver.
module hex8_scan_ctrl
    import hex8_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int SCAN_FREQ  = 1000,
    parameter int NUM_DIGITS = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [31:0] disp_data,
    input  logic [7:0]  dp_mask,
    input  logic [7:0]  blank_mask,
    input  logic        lz_en,
    output logic [15:0] data,
    output logic        s_en,
    output logic        frame_start
);

    localparam int SCAN_DIV = calc_scan_div(CLK_FREQ, SCAN_FREQ);
    localparam int CNT_W    = $clog2(SCAN_DIV);
    localparam int IDX_W    = $clog2(NUM_DIGITS);

    scan_state_t      state, next_state;
    logic [CNT_W-1:0] div_cnt, div_cnt_nxt;
    logic [IDX_W-1:0] digit_idx, idx_nxt;
    logic [31:0]      sh_disp, disp_nxt, disp_shift;
    logic [7:0]       sh_dp, dp_nxt, sh_blank, blank_nxt;
    logic             sh_lz, lz_nxt;
    logic             rise, fall, tick, load, send;
    logic             lead_zero, blank_dig;
    logic [7:0]       seg, sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = en ? SCAN : IDLE;
    end

    // Everything below looks one edge ahead so the registered word matches the
    // digit index and shadow contents that become current on that same edge.
    always_comb begin
        rise        = en && (state == IDLE);
        fall        = !en && (state == SCAN);
        tick        = (state == SCAN) && (div_cnt == CNT_W'(SCAN_DIV - 1));
        load        = rise || (en && tick && (digit_idx == IDX_W'(NUM_DIGITS - 1)));
        send        = rise || (en && tick);
        div_cnt_nxt = '0;
        idx_nxt     = '0;
        if (en && (state == SCAN)) begin
            div_cnt_nxt = tick ? '0 : div_cnt + 1'b1;
            idx_nxt     = digit_idx;
            if (tick) begin
                idx_nxt = (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
            end
        end
        disp_nxt   = load ? disp_data  : sh_disp;
        dp_nxt     = load ? dp_mask    : sh_dp;
        blank_nxt  = load ? blank_mask : sh_blank;
        lz_nxt     = load ? lz_en      : sh_lz;
        disp_shift = disp_nxt >> {idx_nxt, 2'b00};
        lead_zero  = lz_nxt && (idx_nxt != '0) && (disp_shift == 32'd0);
        blank_dig  = blank_nxt[idx_nxt] || lead_zero;
        sel        = ~(8'h01 << idx_nxt);
    end

    hex8_seg_decode u_dec (
        .nibble (disp_shift[3:0]),
        .dp     (dp_nxt[idx_nxt]),
        .blank  (blank_dig),
        .seg    (seg)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt     <= '0;
            digit_idx   <= '0;
            sh_disp     <= '0;
            sh_dp       <= '0;
            sh_blank    <= '0;
            sh_lz       <= 1'b0;
            data        <= {SEG_OFF, SEL_OFF};
            s_en        <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= div_cnt_nxt;
            digit_idx   <= idx_nxt;
            sh_disp     <= disp_nxt;
            sh_dp       <= dp_nxt;
            sh_blank    <= blank_nxt;
            sh_lz       <= lz_nxt;
            s_en        <= send || fall;
            frame_start <= send && (idx_nxt == '0);
            if (fall) begin
                data <= {SEG_OFF, SEL_OFF};
            end else if (send) begin
                data <= {seg, sel};
            end
        end
    end

endmodule

// File: tb/tb_hex8_scan_ctrl.sv
// Scoreboard bench for hex8_scan_ctrl with SCAN_DIV = 10; directed vectors push
// expected strobes, a negedge monitor pops and compares every strobe it sees.
module tb_hex8_scan_ctrl;

    typedef struct packed {
        logic [15:0] data;
        logic        fs;
        logic [31:0] gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic [31:0] disp_data;
    logic [7:0]  dp_mask;
    logic [7:0]  blank_mask;
    logic        lz_en;
    logic [15:0] data;
    logic        s_en;
    logic        frame_start;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   n_strobe = 0;
    exp_t exp_q[$];

    hex8_scan_ctrl #(
        .CLK_FREQ   (1000),
        .SCAN_FREQ  (100),
        .NUM_DIGITS (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .disp_data   (disp_data),
        .dp_mask     (dp_mask),
        .blank_mask  (blank_mask),
        .lz_en       (lz_en),
        .data        (data),
        .s_en        (s_en),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [15:0] d, input logic fs, input int gap);
        exp_t e;
        e.data = d;
        e.fs   = fs;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    // segs[k] is the segment byte expected for digit k
    task automatic push_frame(input logic [7:0][7:0] segs, input int first_gap);
        logic [7:0] sel;
        for (int k = 0; k < 8; k++) begin
            sel = ~(8'h01 << k);
            push_exp({segs[k], sel}, (k == 0), (k == 0) ? first_gap : 10);
        end
    endtask

    task automatic push_blank();
        push_exp(16'hFFFF, 1'b0, 0);
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] d, input logic [7:0] dp,
                                 input logic [7:0] bl, input logic lz);
        disp_data  = d;
        dp_mask    = dp;
        blank_mask = bl;
        lz_en      = lz;
    endtask

    // Monitor: every strobe must match the head of the scoreboard queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (s_en) begin
                n_strobe++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_strobe #%0d: got data=%h, expected no strobe", n_strobe, data);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput($sformatf("strobe%0d_data", n_strobe), {16'h0, data}, {16'h0, e.data});
                    checkOutput($sformatf("strobe%0d_frame_start", n_strobe), {31'h0, frame_start}, {31'h0, e.fs});
                    if (e.gap != 0) begin
                        checkOutput($sformatf("strobe%0d_gap", n_strobe), cyc - last_cyc, e.gap);
                    end
                end
                last_cyc = cyc;
            end
        end
    end

    initial begin
        int idle_strobes;

        // 1: reset with scan enabled and a value held
        reset_n = 1'b0;
        en      = 1'b1;
        applyStimulus(32'h1234_5678, 8'h00, 8'h00, 1'b0);
        wait_edges(3);
        checkOutput("reset_data", {16'h0, data}, 32'h0000_FFFF);
        checkOutput("reset_s_en", {31'h0, s_en}, 32'h0);
        @(negedge clk);
        checkOutput("reset_data_negedge", {16'h0, data}, 32'h0000_FFFF);
        checkOutput("reset_s_en_negedge", {31'h0, s_en}, 32'h0);
        wait_edges(1);
        push_frame({8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80}, 0);
        push_blank();
        reset_n = 1'b1;
        wait_edges(76);
        en = 1'b0;
        wait_edges(5);

        // 2a: leading-zero suppression with a decimal point on digit 1
        applyStimulus(32'h0000_00A0, 8'h02, 8'h00, 1'b1);
        push_frame({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h08, 8'hC0}, 0);
        push_blank();
        en = 1'b1;
        wait_edges(76);
        en = 1'b0;
        wait_edges(5);

        // 2b: same value without suppression
        applyStimulus(32'h0000_00A0, 8'h02, 8'h00, 1'b0);
        push_frame({8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h08, 8'hC0}, 0);
        push_blank();
        en = 1'b1;
        wait_edges(76);
        en = 1'b0;
        wait_edges(5);

        // 3: mid-frame write during digit 3 is held off until the next frame
        applyStimulus(32'h1111_1111, 8'h00, 8'h00, 1'b0);
        push_frame({8{8'hF9}}, 0);
        push_exp(16'hA4FE, 1'b1, 10);
        push_blank();
        en = 1'b1;
        wait_edges(36);
        disp_data = 32'h2222_2222;
        wait_edges(51);
        en = 1'b0;
        wait_edges(5);

        // 4: one-cycle write exactly on the digit-7 tick is captured
        applyStimulus(32'h0000_0000, 8'h00, 8'h00, 1'b0);
        push_frame({8{8'hC0}}, 0);
        push_frame({8'hFF, 8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'hFF}, 10);
        push_exp(16'hC0FE, 1'b1, 10);
        push_blank();
        en = 1'b1;
        wait_edges(80);
        applyStimulus(32'hFFFF_FFFF, 8'h00, 8'h81, 1'b0);
        wait_edges(1);
        applyStimulus(32'h0000_0000, 8'h00, 8'h00, 1'b0);
        wait_edges(85);
        en = 1'b0;
        wait_edges(5);

        // 5: drop en mid-frame, stay idle, then re-enable with a new value
        applyStimulus(32'h1234_5678, 8'h00, 8'h00, 1'b0);
        push_exp(16'h80FE, 1'b1, 0);
        push_exp(16'hF8FD, 1'b0, 10);
        push_exp(16'h82FB, 1'b0, 10);
        push_blank();
        en = 1'b1;
        wait_edges(25);
        en = 1'b0;
        wait_edges(2);
        idle_strobes = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (s_en) idle_strobes++;
        end
        checkOutput("idle_strobes", idle_strobes, 0);
        wait_edges(1);
        applyStimulus(32'hABCD_EF01, 8'h00, 8'h00, 1'b0);
        push_exp(16'hF9FE, 1'b1, 0);
        push_exp(16'hC0FD, 1'b0, 10);
        push_blank();
        en = 1'b1;
        wait_edges(1);
        checkOutput("reenable_s_en", {31'h0, s_en}, 32'h1);
        checkOutput("reenable_data", {16'h0, data}, 32'h0000_F9FE);
        wait_edges(15);
        en = 1'b0;
        wait_edges(5);

        // 6: asynchronous reset between clock edges in the middle of a slot
        applyStimulus(32'h1234_5678, 8'h00, 8'h00, 1'b0);
        push_exp(16'h80FE, 1'b1, 0);
        push_exp(16'hF8FD, 1'b0, 10);
        en = 1'b1;
        wait_edges(16);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_data", {16'h0, data}, 32'h0000_FFFF);
        checkOutput("async_reset_s_en", {31'h0, s_en}, 32'h0);
        checkOutput("async_reset_frame_start", {31'h0, frame_start}, 32'h0);
        wait_edges(3);
        push_exp(16'h80FE, 1'b1, 0);
        push_exp(16'hF8FD, 1'b0, 10);
        push_blank();
        reset_n = 1'b1;
        wait_edges(16);
        en = 1'b0;
        wait_edges(5);

        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
